alu_wb_buffer: RTL and testbench

- Downstream neighbour of the registered ALU. The ALU presents its result and branch outcome one cycle after the operation is issued.
- This block does three things:
  - delays the issue-time valid and transaction ID by one cycle so they align with the registered ALU outputs;
  - queues completed results in a small circular FIFO;
  - hands them to the scoreboard writeback port under a valid/ready handshake.
- It back-pressures issue so that no result already launched into the ALU is ever lost.

---
 rtl/alu_wb_buffer.sv | 120 ++++++++++++
 tb/tb_alu_wb_buffer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: aligns issue valid/ID with the registered ALU outputs, queues results, drives writeback.
// Latency: issue N -> wb_valid_o at N+2 (N+1 when ALU_WB_BYPASS_EN is defined and the FIFO is empty).
// Backpressure: alu_ready_o depends on registers only and always reserves a slot for the in-flight result.
module alu_wb_buffer #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int DEPTH         = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       alu_valid_i,
  input  logic [TRANS_ID_BITS-1:0]   alu_trans_id_i,
  output logic                       alu_ready_o,
  input  logic [XLEN-1:0]            alu_result_i,
  input  logic                       alu_branch_res_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic [XLEN-1:0]            wb_result_o,
  output logic                       wb_branch_res_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [XLEN-1:0]          result;
    logic                     branch;
  } entry_t;

  entry_t                   mem [DEPTH];
  logic                     s1_valid;
  logic [TRANS_ID_BITS-1:0] s1_id;
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            wr_ptr;
  logic [CW-1:0]            count;

  entry_t s1_entry;
  entry_t head;
  logic   accept;
  logic   fifo_nonempty;
  logic   fifo_full;
  logic   bypass_take;
  logic   pop_fifo;
  logic   push;
  logic   push_ok;

  assign s1_entry      = {s1_id, alu_result_i, alu_branch_res_i};
  assign fifo_nonempty = (count != '0);
  assign fifo_full     = (count == DEPTH_C);

  // Reserve one slot for the result already in the ALU: count + in-flight + this issue must fit.
  assign alu_ready_o = ({1'b0, count} + {{CW{1'b0}}, s1_valid} + {{CW{1'b0}}, 1'b1}) <= DEPTH_W;
  assign accept      = alu_valid_i & alu_ready_o & ~flush_i;

`ifdef ALU_WB_BYPASS_EN
  // Empty FIFO: present the freshly registered ALU result directly; consume it if taken.
  logic bypass_sel;
  assign bypass_sel  = ~fifo_nonempty & s1_valid;
  assign wb_valid_o  = fifo_nonempty | s1_valid;
  assign head        = bypass_sel ? s1_entry : mem[rd_ptr];
  assign bypass_take = bypass_sel & wb_ready_i;
`else
  assign wb_valid_o  = fifo_nonempty;
  assign head        = mem[rd_ptr];
  assign bypass_take = 1'b0;
`endif

  assign wb_trans_id_o   = head.id;
  assign wb_result_o     = head.result;
  assign wb_branch_res_o = head.branch;
  assign count_o         = count;

  assign pop_fifo = fifo_nonempty & wb_ready_i;
  // A flushed cycle discards whatever the ALU is presenting.
  assign push     = s1_valid & ~bypass_take & ~flush_i;
  // Guard: never overwrite a full FIFO unless the head leaves in the same cycle.
  assign push_ok  = push & (~fifo_full | pop_fifo);

  // Issue-alignment stage: tracks the op now being computed by the registered ALU.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_id <= alu_trans_id_i;
    end
  end

  // Circular FIFO storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= s1_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_fifo) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_fifo);
      if (push & fifo_full & ~pop_fifo) overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Self-checking bench for alu_wb_buffer: queue-based reference model, directed scenarios and random traffic.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
// Build with +define+ALU_WB_BYPASS_EN to check the bypass variant.
module tb_alu_wb_buffer;
  localparam int XLEN  = 64;
  localparam int TID   = 3;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush, alu_valid, alu_ready, alu_branch;
  logic [TID-1:0]  alu_id, wb_id;
  logic [XLEN-1:0] alu_result, wb_result;
  logic            wb_valid, wb_ready, wb_branch, overflow;
  logic [CW-1:0]   count;

  always #5 clk = ~clk;

  alu_wb_buffer #(.XLEN(XLEN), .TRANS_ID_BITS(TID), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .alu_valid_i(alu_valid), .alu_trans_id_i(alu_id), .alu_ready_o(alu_ready),
    .alu_result_i(alu_result), .alu_branch_res_i(alu_branch),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_trans_id_o(wb_id),
    .wb_result_o(wb_result), .wb_branch_res_o(wb_branch),
    .count_o(count), .overflow_o(overflow)
  );

  typedef struct packed {
    logic [TID-1:0]  id;
    logic [XLEN-1:0] res;
    logic            br;
  } ent_t;

  // Reference model: queued results plus the single op currently inside the ALU.
  ent_t q[$];
  logic m_infl = 1'b0;
  ent_t m_infl_e, next_e;
  logic e_valid, e_ready;
  ent_t e_head;
  int   e_count;
  int   tests = 0;
  int   fails = 0;
`ifdef ALU_WB_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  // Apply one cycle of inputs and compute what the outputs should be this cycle.
  task automatic drive(input logic v, input logic [TID-1:0] id, input logic rdy, input logic fl,
                       input logic [XLEN-1:0] res, input logic br);
    alu_valid = v; alu_id = id; wb_ready = rdy; flush = fl;
    next_e = {id, res, br};
    if (m_infl) begin
      alu_result = m_infl_e.res; alu_branch = m_infl_e.br;
    end else begin
      alu_result = {$urandom, $urandom}; alu_branch = 1'($urandom);
    end
    e_ready = (q.size() + int'(m_infl) + 1) <= DEPTH;
    e_valid = q.size() != 0;
    e_head  = (q.size() != 0) ? q[0] : '0;
`ifdef ALU_WB_BYPASS_EN
    if (q.size() == 0 && m_infl) begin
      e_valid = 1'b1; e_head = m_infl_e;
    end
`endif
    e_count = q.size();
    @(negedge clk);
  endtask

  // Advance the model across the rising edge.
  task automatic tick();
    logic acc, popped, bypassed;
    acc      = alu_valid & e_ready & ~flush;
    popped   = e_valid & wb_ready;
    bypassed = popped && q.size() == 0;
    if (flush) begin
      q.delete();
    end else begin
      if (popped && q.size() != 0) void'(q.pop_front());
      if (m_infl && !bypassed) q.push_back(m_infl_e);
    end
    m_infl   = acc;
    m_infl_e = next_e;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 0; alu_valid = 0; alu_id = '0; wb_ready = 0;
    alu_result = '0; alu_branch = 0;
    #12;
    tests++;
    if ({wb_valid, alu_ready, count, overflow} !== {1'b0, 1'b1, 3'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_ctrl: got valid=%b ready=%b count=%0d ovf=%b, want 0 1 0 0", wb_valid, alu_ready, count, overflow);
    end
    tests++;
    if ({wb_id, wb_result, wb_branch} !== '0) begin
      fails++;
      $display("FAIL reset_fields: got id=%0d res=%h br=%b, want all zero", wb_id, wb_result, wb_branch);
    end
    @(negedge clk); rst_n = 1'b1;
    q.delete(); m_infl = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int seen = -1;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive(1, 3'd3, 1, 0, 64'h1234, 1'b1);
      else        drive(0, 3'd0, 1, 0, {$urandom, $urandom}, 1'($urandom));
      tests++;
      if ({wb_valid, alu_ready, count, overflow} !== {e_valid, e_ready, CW'(e_count), 1'b0}) begin
        fails++;
        $display("FAIL single_ctrl c%0d: got v=%b r=%b cnt=%0d ovf=%b, want v=%b r=%b cnt=%0d ovf=0", c, wb_valid, alu_ready, count, overflow, e_valid, e_ready, e_count);
      end
      if (wb_valid && seen < 0) begin
        seen = c;
        tests++;
        if ({wb_id, wb_result, wb_branch} !== {3'd3, 64'h1234, 1'b1}) begin
          fails++;
          $display("FAIL single_data: got id=%0d res=%h br=%b, want 3 1234 1", wb_id, wb_result, wb_branch);
        end
      end
      tick();
    end
    tests++;
    if (seen != EXP_LAT) begin
      fails++;
      $display("FAIL single_latency: got %0d, want %0d", seen, EXP_LAT);
    end
    tests++;
    if (count !== 3'd0) begin
      fails++;
      $display("FAIL single_count_end: got %0d, want 0", count);
    end
  endtask

  task automatic test_fill();
    for (int c = 0; c < 6; c++) begin
      drive(c < 4, 3'(c), 0, 0, {$urandom, $urandom}, 1'($urandom));
      tests++;
      if ({wb_valid, alu_ready, count, overflow} !== {e_valid, e_ready, CW'(e_count), 1'b0}) begin
        fails++;
        $display("FAIL fill_ctrl c%0d: got v=%b r=%b cnt=%0d ovf=%b, want v=%b r=%b cnt=%0d ovf=0", c, wb_valid, alu_ready, count, overflow, e_valid, e_ready, e_count);
      end
      tests++;
      if (e_valid && {wb_id, wb_result, wb_branch} !== e_head) begin
        fails++;
        $display("FAIL fill_head c%0d: got id=%0d res=%h, want id=%0d res=%h", c, wb_id, wb_result, e_head.id, e_head.res);
      end
      tick();
    end
    tests++;
    if ({count, alu_ready, overflow} !== {3'd4, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL fill_full: got cnt=%0d r=%b ovf=%b, want 4 0 0", count, alu_ready, overflow);
    end
  endtask

  task automatic test_drain();
    int n = 0;
    for (int c = 0; c < 6; c++) begin
      drive(0, 3'd0, 1, 0, {$urandom, $urandom}, 1'($urandom));
      tests++;
      if ({wb_valid, alu_ready, count} !== {e_valid, e_ready, CW'(e_count)}) begin
        fails++;
        $display("FAIL drain_ctrl c%0d: got v=%b r=%b cnt=%0d, want v=%b r=%b cnt=%0d", c, wb_valid, alu_ready, count, e_valid, e_ready, e_count);
      end
      if (c < 4) begin
        tests++;
        if (wb_valid !== 1'b1 || wb_id !== 3'(c)) begin
          fails++;
          $display("FAIL drain_order c%0d: got v=%b id=%0d, want v=1 id=%0d", c, wb_valid, wb_id, c);
        end
      end
      if (c == 1) begin
        tests++;
        if (alu_ready !== 1'b1) begin
          fails++;
          $display("FAIL drain_ready: got %b after first pop, want 1", alu_ready);
        end
      end
      if (wb_valid) n++;
      tick();
    end
    tests++;
    if (n != 4) begin
      fails++;
      $display("FAIL drain_total: got %0d pops, want 4", n);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0, first = -1, last = -1;
    for (int c = 0; c < 14; c++) begin
      drive(c < 10, 3'(c % 8), 1, 0, {$urandom, $urandom}, 1'($urandom));
      tests++;
      if ({wb_valid, alu_ready, count} !== {e_valid, e_ready, CW'(e_count)}) begin
        fails++;
        $display("FAIL b2b_ctrl c%0d: got v=%b r=%b cnt=%0d, want v=%b r=%b cnt=%0d", c, wb_valid, alu_ready, count, e_valid, e_ready, e_count);
      end
      if (wb_valid) begin
        tests++;
        if ({wb_id, wb_result, wb_branch} !== e_head || wb_id !== 3'(n % 8)) begin
          fails++;
          $display("FAIL b2b_data c%0d: got id=%0d res=%h, want id=%0d res=%h", c, wb_id, wb_result, n % 8, e_head.res);
        end
        if (first < 0) first = c;
        last = c;
        n++;
      end
      tick();
    end
    tests++;
    if (n != 10 || last - first != 9) begin
      fails++;
      $display("FAIL b2b_rate: got %0d results over %0d cycles, want 10 over 10", n, last - first + 1);
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 7; c++) begin
      if (c < 3)       drive(1, 3'(5 + c), 0, 0, {$urandom, $urandom}, 1'($urandom));
      else if (c == 3) drive(1, 3'd1, 0, 1, {$urandom, $urandom}, 1'($urandom));
      else             drive(0, 3'd0, 0, 0, {$urandom, $urandom}, 1'($urandom));
      tests++;
      if ({wb_valid, alu_ready, count} !== {e_valid, e_ready, CW'(e_count)}) begin
        fails++;
        $display("FAIL flush_ctrl c%0d: got v=%b r=%b cnt=%0d, want v=%b r=%b cnt=%0d", c, wb_valid, alu_ready, count, e_valid, e_ready, e_count);
      end
      if (c == 3) begin
        tests++;
        if (count !== 3'd2) begin
          fails++;
          $display("FAIL flush_pre: got cnt=%0d, want 2", count);
        end
      end
      if (c >= 4) begin
        tests++;
        if (wb_valid !== 1'b0 || count !== 3'd0) begin
          fails++;
          $display("FAIL flush_post c%0d: got v=%b cnt=%0d, want 0 0", c, wb_valid, count);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 4; c++) begin
      drive(c < 3, 3'(c), 0, 0, {$urandom, $urandom}, 1'($urandom));
      tick();
    end
    drive(0, 3'd0, 0, 0, {$urandom, $urandom}, 1'($urandom));
    tests++;
    if (count !== 3'd3) begin
      fails++;
      $display("FAIL rstmid_pre: got cnt=%0d, want 3", count);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({wb_valid, count, alu_ready, overflow} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL rstmid: got v=%b cnt=%0d r=%b ovf=%b, want 0 0 1 0", wb_valid, count, alu_ready, overflow);
    end
    q.delete(); m_infl = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom_range(0, 2) != 0),
            $urandom_range(0, 24) == 0, {$urandom, $urandom}, 1'($urandom));
      tests++;
      if ({wb_valid, alu_ready, count, overflow} !== {e_valid, e_ready, CW'(e_count), 1'b0}) begin
        fails++;
        $display("FAIL rand_ctrl c%0d: got v=%b r=%b cnt=%0d ovf=%b, want v=%b r=%b cnt=%0d ovf=0", c, wb_valid, alu_ready, count, overflow, e_valid, e_ready, e_count);
      end
      if (e_valid) begin
        tests++;
        if ({wb_id, wb_result, wb_branch} !== e_head) begin
          fails++;
          $display("FAIL rand_head c%0d: got id=%0d res=%h br=%b, want id=%0d res=%h br=%b", c, wb_id, wb_result, wb_branch, e_head.id, e_head.res, e_head.br);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
